// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Performs a WIDTH-bit addition by reusing one 4-bit carry-look-ahead slice,
//   one nibble per cycle, least-significant nibble first. A carry register
//   links consecutive nibbles. Latency is traded for area.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present            in_ready   block can accept operands
//   A, B       WIDTH-bit operands             Cin        carry in
//   out_valid  result valid                   out_ready  consumer accepts result
//   Sum        registered WIDTH-bit sum       Cout       registered carry out
//   Overflow   registered two's-complement overflow
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [5:0]       w_slice;
  logic [3:0]       w_s;
  logic             w_c3;
  logic             w_c4;

  // 4-bit carry-look-ahead slice; returns {c4, c3, sum[3:0]}.
  // c3 is kept so overflow can be formed from carry into/out of the MSB.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  // Nibble selection for the shared slice
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
  end

  assign w_slice = cla4(w_a_nib, w_b_nib, r_carry);
  assign w_c4    = w_slice[5];
  assign w_c3    = w_slice[4];
  assign w_s     = w_slice[3:0];

  // Sequencer: capture, nibble-serial accumulate, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDXW'(n)) r_sum[4*n +: 4] <= w_s;
          end
          r_carry <= w_c4;
          if (r_idx == LAST_IDX) begin
            // Final nibble carries the MSB, so the flags are formed here
            r_cout  <= w_c4;
            r_ovf   <= w_c3 ^ w_c4;
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshakes decode state only; no combinational path from the inputs
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Overflow  = r_ovf;

endmodule
